alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered successor to the 16-bit combinational ALU.
//  - Adds a valid/ready handshake on both sides, B-driven variable shift amounts and a multi-cycle unsigned multiply.
//  - Sits between operand/register-read logic and write-back: one op in flight, result held until consumed.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be >=4 and a power of 2
//  SHW    4   shift-amount width, = log2(WIDTH); shift amount is B[SHW-1:0]
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      op/operands valid
//  in_ready   out  1      block can accept an op
//  op         in   4      operation select (table below)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B / shift amount
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  res        out  WIDTH  result (low half for MUL)
//  res_hi     out  WIDTH  MUL high half; 0 for all other ops
//  overflow   out  1      overflow flag for the result
//  zero       out  1      1 when res == 0 (res_hi is ignored)
// BEHAVIOUR
//  Op codes: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 DEC, 5 INC, 6 NOT A, 7 SLA, 8 SRA, 9 SLL, A SRL, B SLT (signed), C MUL.
//  Op codes D-F are NOP: they produce res=0, overflow=0, zero=1 with 1-cycle latency.
//  FSM states:
//  - IDLE: in_ready=1. On in_valid, a, b and op are captured.
//    - Non-MUL op: goes to DONE at the next edge.
//    - MUL: goes to BUSY.
//  - BUSY: shift-add multiply, one multiplier bit per cycle, with counter 0..WIDTH-1. Goes to DONE after WIDTH cycles.
//  - DONE: out_valid=1. res, res_hi, overflow and zero stay stable.
//    - out_ready=1: back to IDLE at that edge.
//    - No same-cycle accept of a new op: throughput is at most 1 op per 2 cycles.
//  Latency from accept edge to out_valid: non-MUL = 1 cycle; MUL = WIDTH+1 cycles.
//  in_ready=0 in BUSY and in DONE. in_valid asserted then is ignored and not queued.
//  Arithmetic is modulo 2^WIDTH.
//  Overflow definitions:
//  - ADD, SUB, INC, DEC: signed two's-complement overflow (operand signs vs result sign).
//  - SLL: any 1 bit shifted out.
//  - SLA: A differs from (res >>> shamt) arithmetic, i.e. the sign was lost.
//  - SRA, SRL, logic ops, SLT: 0.
//  - MUL (unsigned 2*WIDTH product): overflow = (res_hi != 0).
//  shamt = 0: res = A, overflow = 0.
//  SLT: res = {WIDTH-1 zeros, (signed A < signed B)}.
//  Reset (async, any state including mid-MUL): state=IDLE, counter=0, res=0, res_hi=0, overflow=0, zero=1, out_valid=0, in_ready=1.
//  A partial product in progress is discarded.
//  Outputs change only on a clock edge; no combinational path from inputs to outputs except in_ready (state-derived only).
// TESTING (WIDTH=16 unless noted)
//  1. ADD 0x7FFF+0x0001, out_ready=1 -> next cycle out_valid=1, res=0x8000, overflow=1, zero=0.
//  2. SUB 0x1234-0x1234 -> res=0x0000, zero=1, overflow=0; SLT 0xFFFF,0x0001 -> res=0x0001.
//  3. SLL a=0xC001 b=1 -> res=0x8002, overflow=1; SRA a=0x8000 b=15 -> res=0xFFFF, overflow=0.
//  4. MUL 0xFFFF*0xFFFF -> in_ready=0 for 17 cycles; out_valid after 17 cycles; res=0x0001, res_hi=0xFFFE, overflow=1.
//  5. out_ready=0 for 5 cycles with in_valid held -> result held stable, second op not accepted until 1 cycle after out_ready.
//  6. Assert rst at cycle 8 of a MUL -> immediate IDLE, out_valid=0, zero=1; next ADD 2+3 -> res=5.
//     Rerun scenarios 1 and 4 with WIDTH=8: MUL 0xFF*0xFF -> res=0x01, res_hi=0xFE.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready handshake on both sides and a shift-add unsigned multiply.
// Latency: 1 cycle for non-MUL ops and WIDTH+1 cycles for MUL, counted from the accept edge to out_valid.
// Backpressure: one op in flight; the result is held until out_ready; in_ready is low in BUSY and DONE.
// Ports: clk, rst (async, active-high); in_valid/in_ready with op, a, b;
//        out_valid/out_ready with res, res_hi (MUL high half), overflow, zero.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_DEC = 4'h4;
  localparam logic [3:0] OP_INC = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SLA = 4'h7;
  localparam logic [3:0] OP_SRA = 4'h8;
  localparam logic [3:0] OP_SLL = 4'h9;
  localparam logic [3:0] OP_SRL = 4'hA;
  localparam logic [3:0] OP_SLT = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [WIDTH-1:0]     res_hi_q, res_hi_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;
  logic                 out_valid_q, out_valid_d;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovf;
  logic [WIDTH-1:0]     add_res, sub_res, inc_res, dec_res;
  logic [2*WIDTH-1:0]   sll_wide;
  logic [WIDTH-1:0]     sla_back;

  // Multiply step: {prod_hi, prod_lo} holds the partial product in the upper half
  // and the unconsumed multiplier bits in the lower half.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  always_comb begin
    shamt    = b[SHW-1:0];
    add_res  = a + b;
    sub_res  = a - b;
    inc_res  = a + ONE;
    dec_res  = a - ONE;
    sll_wide = {{WIDTH{1'b0}}, a} << shamt;
    // Shifting the SLA result back arithmetically recovers A only if no
    // significant bit (including the sign) was lost.
    sla_back = $signed(sll_wide[WIDTH-1:0]) >>> shamt;
    alu_res  = '0;
    alu_ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  alu_res = a | b;
      OP_AND: alu_res = a & b;
      OP_DEC: begin
        alu_res = dec_res;
        alu_ovf = a[WIDTH-1] && !dec_res[WIDTH-1];
      end
      OP_INC: begin
        alu_res = inc_res;
        alu_ovf = !a[WIDTH-1] && inc_res[WIDTH-1];
      end
      OP_NOT: alu_res = ~a;
      OP_SLA: begin
        alu_res = sll_wide[WIDTH-1:0];
        alu_ovf = (sla_back != a);
      end
      OP_SRA: alu_res = $signed(a) >>> shamt;
      OP_SLL: begin
        alu_res = sll_wide[WIDTH-1:0];
        alu_ovf = |sll_wide[2*WIDTH-1:WIDTH];
      end
      OP_SRL: alu_res = a >> shamt;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: begin
        // NOP codes (and MUL, which never uses this path) yield zero.
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
             + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    res_d       = res_q;
    res_hi_d    = res_hi_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
          end else begin
            state_d     = S_DONE;
            res_d       = alu_res;
            res_hi_d    = '0;
            ovf_d       = alu_ovf;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          res_d       = mul_next[WIDTH-1:0];
          res_hi_d    = mul_next[2*WIDTH-1:WIDTH];
          ovf_d       = |mul_next[2*WIDTH-1:WIDTH];
          zero_d      = (mul_next[WIDTH-1:0] == '0);
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        // Results stay frozen until consumed; a new op can only be taken
        // once back in IDLE.
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      res_q       <= '0;
      res_hi_q    <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      res_q       <= res_d;
      res_hi_q    <= res_hi_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign res_hi    = res_hi_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 16-bit and an 8-bit instance share clock and reset.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [3:0]  op = 4'h0;
  logic [15:0] a = '0, b = '0, res, res_hi;
  logic        overflow, zero;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
  logic [3:0]  op8 = 4'h0;
  logic [7:0]  a8 = '0, b8 = '0, res8, res_hi8;
  logic        overflow8, zero8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .res_hi(res_hi), .overflow(overflow), .zero(zero)
  );

  alu_seq #(.WIDTH(8), .SHW(3)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .res(res8),
    .res_hi(res_hi8), .overflow(overflow8), .zero(zero8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, presents one op for a single accept edge.
  task automatic issue(input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb);
    int n = 0;
    while (!in_ready8 && n < 50) begin
      step();
      n++;
    end
    chk("in_ready8_before_issue", {31'd0, in_ready8}, 32'd1);
    op8 = o; a8 = aa; b8 = bb; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [15:0] r, input logic ov, input logic z);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"},   {16'd0, res},       {16'd0, r});
    chk({tag, "_ovf"},   {31'd0, overflow},  {31'd0, ov});
    chk({tag, "_zero"},  {31'd0, zero},      {31'd0, z});
  endtask

  initial begin
    int n;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res",       {16'd0, res},       32'd0);
    chk("rst_res_hi",    {16'd0, res_hi},    32'd0);
    chk("rst_ovf",       {31'd0, overflow},  32'd0);
    chk("rst_zero",      {31'd0, zero},      32'd1);

    // One-cycle ops: out_valid is already up right after the accept edge.
    issue(4'h0, 16'h7FFF, 16'h0001); expect_res("add_ovf", 16'h8000, 1'b1, 1'b0);
    chk("add_res_hi", {16'd0, res_hi}, 32'd0);
    chk("add_in_ready_done", {31'd0, in_ready}, 32'd0);
    issue(4'h1, 16'h1234, 16'h1234); expect_res("sub_zero", 16'h0000, 1'b0, 1'b1);
    issue(4'hB, 16'hFFFF, 16'h0001); expect_res("slt",      16'h0001, 1'b0, 1'b0);
    issue(4'h9, 16'hC001, 16'h0001); expect_res("sll",      16'h8002, 1'b1, 1'b0);
    issue(4'h8, 16'h8000, 16'h000F); expect_res("sra",      16'hFFFF, 1'b0, 1'b0);
    issue(4'hA, 16'h8000, 16'h000F); expect_res("srl",      16'h0001, 1'b0, 1'b0);
    issue(4'h7, 16'h4000, 16'h0001); expect_res("sla_ovf",  16'h8000, 1'b1, 1'b0);
    issue(4'h7, 16'hFFF0, 16'h0002); expect_res("sla_ok",   16'hFFC0, 1'b0, 1'b0);
    issue(4'h9, 16'hABCD, 16'h0010); expect_res("sll_sh0",  16'hABCD, 1'b0, 1'b0);
    issue(4'h5, 16'h7FFF, 16'h0000); expect_res("inc",      16'h8000, 1'b1, 1'b0);
    issue(4'h4, 16'h8000, 16'h0000); expect_res("dec",      16'h7FFF, 1'b1, 1'b0);
    issue(4'h6, 16'h00FF, 16'h0000); expect_res("not",      16'hFF00, 1'b0, 1'b0);
    issue(4'h2, 16'hF000, 16'h000F); expect_res("or",       16'hF00F, 1'b0, 1'b0);
    issue(4'h3, 16'hF0F0, 16'h0FF0); expect_res("and",      16'h00F0, 1'b0, 1'b0);
    issue(4'hE, 16'h1234, 16'h5678); expect_res("nop",      16'h0000, 1'b0, 1'b1);

    // MUL: 16 BUSY edges after the accept edge, so 17 edges in total.
    issue(4'hC, 16'hFFFF, 16'hFFFF);
    chk("mul_in_ready_busy", {31'd0, in_ready}, 32'd0);
    n = 1;
    while (!out_valid && n < 100) begin
      chk("mul_in_ready_low", {31'd0, in_ready}, 32'd0);
      step();
      n++;
    end
    chk("mul_latency", n, 32'd17);
    expect_res("mul", 16'h0001, 1'b1, 1'b0);
    chk("mul_res_hi", {16'd0, res_hi}, 32'h0000FFFE);
    chk("mul_in_ready_done", {31'd0, in_ready}, 32'd0);
    step();
    chk("mul_in_ready_after", {31'd0, in_ready}, 32'd1);

    // Backpressure: result held while a second op is waiting on in_valid.
    out_ready = 1'b0;
    issue(4'h0, 16'h0001, 16'h0002);
    op = 4'h0; a = 16'h0010; b = 16'h0020; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_res",   {16'd0, res},       32'd3);
      chk("hold_res_hi",{16'd0, res_hi},    32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("release_valid",    {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready},  32'd1);
    step();
    in_valid = 1'b0;
    expect_res("second_op", 16'h0030, 1'b0, 1'b0);
    step();

    // Reset in the middle of a MUL
    issue(4'hC, 16'hFFFF, 16'hFFFF);
    repeat (7) step();
    chk("pre_rst_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst_zero",      {31'd0, zero},      32'd1);
    chk("midrst_res_hi",    {16'd0, res_hi},    32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    issue(4'h0, 16'h0002, 16'h0003); expect_res("add_after_rst", 16'h0005, 1'b0, 1'b0);
    step();

    // 8-bit instance
    issue8(4'h0, 8'h7F, 8'h01);
    chk("w8_add_valid", {31'd0, out_valid8}, 32'd1);
    chk("w8_add_res",   {24'd0, res8},       32'h80);
    chk("w8_add_ovf",   {31'd0, overflow8},  32'd1);
    chk("w8_add_zero",  {31'd0, zero8},      32'd0);
    step();
    issue8(4'hC, 8'hFF, 8'hFF);
    n = 1;
    while (!out_valid8 && n < 100) begin
      step();
      n++;
    end
    chk("w8_mul_latency", n, 32'd9);
    chk("w8_mul_res",    {24'd0, res8},      32'h01);
    chk("w8_mul_res_hi", {24'd0, res_hi8},   32'hFE);
    chk("w8_mul_ovf",    {31'd0, overflow8}, 32'd1);
    step();
    chk("w8_in_ready_after", {31'd0, in_ready8}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
